// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver for the pipelined RV32I core. It predicts at fetch from a
// table of 2-bit saturating counters, resolves branches in EX and keeps branch statistics.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  CTR_INIT    = 2'b01,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [2:0]        ex_func3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic              zf,
  input  logic              cf,
  input  logic              sf,
  input  logic              vf,
  input  logic              stall,
  output logic [1:0]        branch_sel,
  output logic              mispredict,
  output logic              illegal_branch,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_d [BHT_ENTRIES];
  logic [STAT_W-1:0] branch_count_q, branch_count_d;
  logic [STAT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic              illegal_q, illegal_d;

  logic [IdxW-1:0] if_idx, ex_idx;
  logic            cond, resolved_taken, retire, retire_branch, func3_illegal;

  // PC bits outside the index field do not select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IdxW+2], if_pc[1:0], ex_pc[XLEN-1:IdxW+2], ex_pc[1:0]};

  assign if_idx        = if_pc[IdxW+1:2];
  assign ex_idx        = ex_pc[IdxW+1:2];
  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    cond = 1'b0;
    case (ex_func3)
      3'd0:    cond = zf;
      3'd1:    cond = !zf;
      3'd4:    cond = (sf != vf);
      3'd5:    cond = (sf == vf);
      3'd6:    cond = !cf;
      3'd7:    cond = cf;
      default: cond = 1'b0;
    endcase
  end

  assign func3_illegal  = (ex_func3 == 3'd2) || (ex_func3 == 3'd3);
  assign resolved_taken = ex_jump | (ex_branch & cond);
  assign branch_sel     = {ex_valid & ex_jump, ex_valid & resolved_taken};
  assign mispredict     = ex_valid & (ex_branch | ex_jump) & (resolved_taken != ex_pred_taken);
  assign retire         = ex_valid & !stall & (ex_branch | ex_jump);
  // A branch flagged together with a jump behaves purely as a jump.
  assign retire_branch  = retire & ex_branch & !ex_jump;

  always_comb begin
    bht_d = bht_q;
    if (retire_branch) begin
      if (resolved_taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    illegal_d          = illegal_q;
    if (!stall) begin
      illegal_d = retire_branch & func3_illegal;
      if (retire_branch)           branch_count_d     = branch_count_q + STAT_W'(1);
      if (retire && mispredict)    mispredict_count_d = mispredict_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= CTR_INIT;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      illegal_q          <= 1'b0;
    end else begin
      bht_q              <= bht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      illegal_q          <= illegal_d;
    end
  end

  assign illegal_branch   = illegal_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with default parameters (64 entries, CTR_INIT=01).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_branch, ex_jump;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        zf, cf, sf, vf, stall;
  logic [1:0]  branch_sel;
  logic        mispredict, illegal_branch;
  logic [31:0] branch_count, mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .ex_func3         (ex_func3),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .zf               (zf),
    .cf               (cf),
    .sf               (sf),
    .vf               (vf),
    .stall            (stall),
    .branch_sel       (branch_sel),
    .mispredict       (mispredict),
    .illegal_branch   (illegal_branch),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_func3 = 3'd0; ex_pc = 32'h0;
    ex_pred_taken = 0; zf = 0; cf = 0; sf = 0; vf = 0; stall = 0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic z,
                        input logic pred);
    ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_func3 = f3; ex_pc = pc;
    zf = z; ex_pred_taken = pred;
  endtask

  task automatic test_reset();
    rst = 1; clear_ex(); if_pc = 0;
    step();
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4); #1;
      n_cmp++;
      if (if_pred_taken !== 1'b0) begin
        n_err++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, if_pred_taken);
      end
    end
    n_cmp++;
    if (branch_count !== 0 || mispredict_count !== 0 || illegal_branch !== 0) begin
      n_err++; $display("FAIL reset_state got bc=%0d mc=%0d ill=%b exp=0/0/0",
                        branch_count, mispredict_count, illegal_branch);
    end
    rst = 0;
    step();
  endtask

  task automatic test_first_branch();
    branch(3'd0, 32'h100, 1'b1, 1'b0); if_pc = 32'h100; #1;
    n_cmp++;
    if (branch_sel !== 2'b01 || mispredict !== 1'b1) begin
      n_err++; $display("FAIL beq_comb got sel=%b misp=%b exp=01/1", branch_sel, mispredict);
    end
    step(); clear_ex(); #1;
    n_cmp++;
    if (if_pred_taken !== 1'b1 || branch_count !== 1 || mispredict_count !== 1) begin
      n_err++; $display("FAIL beq_update got pred=%b bc=%0d mc=%0d exp=1/1/1",
                        if_pred_taken, branch_count, mispredict_count);
    end
  endtask

  task automatic test_saturation();
    if_pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      branch(3'd1, 32'h200, 1'b0, 1'b1); step();
    end
    branch(3'd1, 32'h200, 1'b1, 1'b1); step(); clear_ex(); #1;
    n_cmp++;
    if (if_pred_taken !== 1'b1) begin
      n_err++; $display("FAIL sat_one_down got=%b exp=1", if_pred_taken);
    end
    branch(3'd1, 32'h200, 1'b1, 1'b1); step(); clear_ex(); #1;
    n_cmp++;
    if (if_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL sat_two_down got=%b exp=0", if_pred_taken);
    end
    n_cmp++;
    if (branch_count !== 8 || mispredict_count !== 3) begin
      n_err++; $display("FAIL sat_counts got bc=%0d mc=%0d exp=8/3",
                        branch_count, mispredict_count);
    end
  endtask

  task automatic test_alias_no_bypass();
    if_pc = 32'h204;
    branch(3'd0, 32'h104, 1'b1, 1'b1); #1;
    n_cmp++;
    if (if_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL alias_same_cycle got=%b exp=0", if_pred_taken);
    end
    step(); clear_ex(); #1;
    n_cmp++;
    if (if_pred_taken !== 1'b1 || branch_count !== 9) begin
      n_err++; $display("FAIL alias_next_cycle got pred=%b bc=%0d exp=1/9",
                        if_pred_taken, branch_count);
    end
  endtask

  task automatic test_flags_sweep();
    // {func3, cf, sf, vf, expected taken}
    logic [6:0] vec [12];
    logic [6:0] v;
    vec = '{{3'd4, 3'b000, 1'b0}, {3'd4, 3'b001, 1'b1}, {3'd4, 3'b010, 1'b1},
            {3'd4, 3'b011, 1'b0}, {3'd5, 3'b000, 1'b1}, {3'd5, 3'b001, 1'b0},
            {3'd5, 3'b010, 1'b0}, {3'd5, 3'b011, 1'b1}, {3'd6, 3'b000, 1'b1},
            {3'd6, 3'b100, 1'b0}, {3'd7, 3'b000, 1'b0}, {3'd7, 3'b100, 1'b1}};
    for (int i = 0; i < 12; i++) begin
      v = vec[i];
      branch(v[6:4], 32'h40, 1'b0, 1'b0);
      stall = 1; cf = v[3]; sf = v[2]; vf = v[1]; #1;
      n_cmp++;
      if (branch_sel !== {1'b0, v[0]} || mispredict !== v[0]) begin
        n_err++; $display("FAIL flags_sweep f3=%0d cf/sf/vf=%b got sel=%b misp=%b exp=0%b",
                          v[6:4], v[3:1], branch_sel, mispredict, v[0]);
      end
      step();
    end
    clear_ex(); #1;
    n_cmp++;
    if (branch_count !== 9 || mispredict_count !== 3) begin
      n_err++; $display("FAIL flags_stalled_counts got bc=%0d mc=%0d exp=9/3",
                        branch_count, mispredict_count);
    end
  endtask

  task automatic test_jump_stall();
    if_pc = 32'h0;
    ex_valid = 1; ex_jump = 1; ex_pc = 32'h300; ex_pred_taken = 0; #1;
    n_cmp++;
    if (branch_sel !== 2'b11 || mispredict !== 1'b1) begin
      n_err++; $display("FAIL jal_comb got sel=%b misp=%b exp=11/1", branch_sel, mispredict);
    end
    step();
    n_cmp++;
    if (mispredict_count !== 4 || branch_count !== 9 || if_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL jal_retire got mc=%0d bc=%0d pred=%b exp=4/9/0",
                        mispredict_count, branch_count, if_pred_taken);
    end
    stall = 1; ex_branch = 1; ex_func3 = 3'd2;
    repeat (3) step();
    n_cmp++;
    if (mispredict_count !== 4 || branch_count !== 9 || illegal_branch !== 1'b0) begin
      n_err++; $display("FAIL stall_hold got mc=%0d bc=%0d ill=%b exp=4/9/0",
                        mispredict_count, branch_count, illegal_branch);
    end
    // Branch and jump together behave as a jump: no counter or branch_count change.
    clear_ex();
    branch(3'd0, 32'h08, 1'b1, 1'b1); ex_jump = 1; if_pc = 32'h08; #1;
    n_cmp++;
    if (branch_sel !== 2'b11 || mispredict !== 1'b0) begin
      n_err++; $display("FAIL br_jump_comb got sel=%b misp=%b exp=11/0", branch_sel, mispredict);
    end
    step(); clear_ex(); #1;
    n_cmp++;
    if (branch_count !== 9 || mispredict_count !== 4 || if_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL br_jump_retire got bc=%0d mc=%0d pred=%b exp=9/4/0",
                        branch_count, mispredict_count, if_pred_taken);
    end
  endtask

  task automatic test_illegal();
    branch(3'd2, 32'h0C, 1'b1, 1'b0); #1;
    n_cmp++;
    if (branch_sel !== 2'b00 || mispredict !== 1'b0 || illegal_branch !== 1'b0) begin
      n_err++; $display("FAIL illegal_comb got sel=%b misp=%b ill=%b exp=00/0/0",
                        branch_sel, mispredict, illegal_branch);
    end
    step(); clear_ex(); #1;
    n_cmp++;
    if (illegal_branch !== 1'b1 || branch_count !== 10) begin
      n_err++; $display("FAIL illegal_pulse got ill=%b bc=%0d exp=1/10",
                        illegal_branch, branch_count);
    end
    step();
    n_cmp++;
    if (illegal_branch !== 1'b0) begin
      n_err++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal_branch);
    end
  endtask

  task automatic test_async_reset();
    if_pc = 32'h100;
    rst = 1; #1;
    n_cmp++;
    if (branch_count !== 0 || mispredict_count !== 0 || if_pred_taken !== 1'b0) begin
      n_err++; $display("FAIL async_reset got bc=%0d mc=%0d pred=%b exp=0/0/0",
                        branch_count, mispredict_count, if_pred_taken);
    end
    step(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_first_branch();
    test_saturation();
    test_alias_no_bypass();
    test_flags_sweep();
    test_jump_stall();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
